// File: rtl/gfp8_fp16_converter.sv
// -----------------------------------------------------------------------------
// gfp8_fp16_converter
//   Converts one GFP8 dot-product result (signed mantissa M times 2^E) into an
//   IEEE 754 binary16 value with round-to-nearest-even. The arithmetic is
//   purely combinational and feeds a single output register, so a result
//   appears one clock after its input, and one input is accepted per clock.
//
// Ports:
//   i_clk           clock, all state on the rising edge
//   i_reset_n       synchronous active-low reset
//   i_gfp_mantissa  two's-complement mantissa M
//   i_gfp_exponent  two's-complement exponent E
//   i_valid         input qualifier
//   o_fp16_result   registered FP16 {sign, exp[4:0], frac[9:0]}
//   o_valid         registered result qualifier
// -----------------------------------------------------------------------------
module gfp8_fp16_converter #(
  parameter int MAN_WIDTH = 32,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [MAN_WIDTH-1:0] i_gfp_mantissa,
  input  logic [EXP_WIDTH-1:0] i_gfp_exponent,
  input  logic                 i_valid,
  output logic [15:0]          o_fp16_result,
  output logic                 o_valid
);

  localparam int PW = $clog2(MAN_WIDTH);
  // Exponent arithmetic width: wide enough that p + E + 15 and 1 - B never wrap.
  localparam int XW = EXP_WIDTH + PW + 4;
  // Normalised magnitude plus 11 zero bits so frac/guard/sticky always exist.
  localparam int NW = MAN_WIDTH + 11;

  localparam logic signed [XW-1:0] ONE_C  = XW'(1);
  localparam logic signed [XW-1:0] BIAS_C = XW'(15);
  localparam logic signed [XW-1:0] MAXB_C = XW'(31);

  // Index of the most significant set bit (0 when no bit is set).
  function automatic logic [PW-1:0] lead_one(input logic [MAN_WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAN_WIDTH; i++) begin
      idx = v[i] ? PW'(i) : idx;
    end
    return idx;
  endfunction

  // Round-to-nearest-even increment decision.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  logic                  sign_s;
  logic [MAN_WIDTH-1:0]  mag_s;
  logic [PW-1:0]         lead_s;
  logic [PW-1:0]         lsh_s;
  logic signed [XW-1:0]  lead_ext_s;
  logic signed [XW-1:0]  exp_ext_s;
  logic signed [XW-1:0]  b_s;
  logic signed [XW-1:0]  b_rnd_s;
  logic signed [XW-1:0]  k_s;
  logic [NW-1:0]         norm_s;
  logic [9:0]            frac_s;
  logic [9:0]            frac_rnd_s;
  logic                  carry_s;
  logic [2*NW-1:0]       sub_vec_s;
  logic [10:0]           sub_int_s;
  logic [10:0]           r_s;
  logic [15:0]           result_s;
  logic [15:0]           result_r;
  logic                  valid_r;

  // Combinational conversion of the current input into its FP16 encoding.
  always_comb begin
    sign_s     = i_gfp_mantissa[MAN_WIDTH-1];
    // Two's-complement negate; the most negative M maps to 2^(W-1) unsigned.
    mag_s      = sign_s ? (~i_gfp_mantissa + {{(MAN_WIDTH-1){1'b0}}, 1'b1}) : i_gfp_mantissa;
    lead_s     = lead_one(mag_s);
    lsh_s      = PW'(MAN_WIDTH - 1) - lead_s;
    lead_ext_s = {{(XW-PW){1'b0}}, lead_s};
    exp_ext_s  = {{(XW-EXP_WIDTH){i_gfp_exponent[EXP_WIDTH-1]}}, i_gfp_exponent};
    b_s        = lead_ext_s + exp_ext_s + BIAS_C;

    // Leading one moved to the MSB; the 10 bits under it are the fraction.
    norm_s = {mag_s, 11'b0} << lsh_s;
    frac_s = norm_s[NW-2 -: 10];
    {carry_s, frac_rnd_s} = {1'b0, frac_s}
                          + {10'b0, rne_inc(norm_s[NW-12], |norm_s[NW-13:0], frac_s[0])};
    b_rnd_s = b_s + {{(XW-1){1'b0}}, carry_s};

    // Subnormal: the 11-bit significand shifted right by 1-B lands in units of
    // 2^-24. The double-width vector keeps every shifted-out bit for sticky.
    k_s       = ONE_C - b_s;
    sub_vec_s = {norm_s, {NW{1'b0}}} >> $unsigned(k_s);
    sub_int_s = sub_vec_s[2*NW-1 -: 11];
    r_s       = sub_int_s
              + {10'b0, rne_inc(sub_vec_s[2*NW-12], |sub_vec_s[2*NW-13:0], sub_int_s[0])};

    if (mag_s == {MAN_WIDTH{1'b0}}) begin
      result_s = 16'h0000;
    end else if (b_s >= ONE_C) begin
      if (b_rnd_s >= MAXB_C) begin
        result_s = {sign_s, 5'b11111, 10'b0};
      end else begin
        result_s = {sign_s, b_rnd_s[4:0], frac_rnd_s};
      end
    end else if (r_s == 11'd0) begin
      result_s = 16'h0000;
    end else begin
      // R = 1024 falls out as exponent field 1, fraction 0: min normal.
      result_s = {sign_s, 4'b0000, r_s};
    end
  end

  // Output register: valid follows input every cycle, result only on valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      result_r <= 16'h0000;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= i_valid;
      if (i_valid) begin
        result_r <= result_s;
      end
    end
  end

  assign o_fp16_result = result_r;
  assign o_valid       = valid_r;

endmodule

// File: tb/tb_gfp8_fp16_converter.sv
// -----------------------------------------------------------------------------
// tb_gfp8_fp16_converter
//   Self-checking bench. A real-number reference model computes the exact
//   FP16 rounding of M * 2^E; an expectation register tracks what the outputs
//   must be each cycle and one compare process checks them on every falling
//   edge. Directed vectors come first, then randomized traffic with
//   occasional resets.
// -----------------------------------------------------------------------------
module tb_gfp8_fp16_converter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m;
  logic [7:0]  e;
  logic        valid;
  logic [15:0] res;
  logic        res_valid;

  logic [15:0] exp_res;
  logic        exp_valid;
  logic        exp_known;
  logic        done;

  int total;
  int bad;

  localparam int NDIR = 14;
  localparam logic [31:0] DM [NDIR] = '{
    32'd1, 32'hFFFFFFFD, 32'd0, 32'd2049, 32'd2051, 32'h80000000, 32'd2047,
    32'd4095, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd3, 32'd1023, 32'd2047};
  localparam logic [7:0] DE [NDIR] = '{
    8'd0, 8'hFF, 8'd5, 8'd0, 8'd0, 8'hE1, 8'd5,
    8'd4, 8'd16, 8'hE8, 8'hE7, 8'hE7, 8'hE8, 8'hE7};
  localparam logic [15:0] DX [NDIR] = '{
    16'h3C00, 16'hBE00, 16'h0000, 16'h6800, 16'h6802, 16'hBC00, 16'h7BFF,
    16'h7C00, 16'hFC00, 16'h0001, 16'h0000, 16'h0002, 16'h03FF, 16'h0400};

  gfp8_fp16_converter #(.MAN_WIDTH(32), .EXP_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_gfp_mantissa (m),
    .i_gfp_exponent (e),
    .i_valid        (valid),
    .o_fp16_result  (res),
    .o_valid        (res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact value a*2^E in a double, rounded to the FP16 grid with ties-to-even.
  function automatic logic [15:0] ref_fp16(input logic signed [31:0] mm, input logic signed [7:0] ee);
    longint a;
    real    v;
    real    t;
    real    n;
    real    fr;
    int     ex;
    int     qe;
    int     rn;
    int     ei;
    logic   s;
    if (mm == 0) return 16'h0000;
    s  = (mm < 0);
    a  = s ? -longint'(mm) : longint'(mm);
    ei = int'(ee);
    v  = real'(a);
    if (ei > 0) for (int i = 0; i < ei; i++) v = v * 2.0;
    else        for (int i = 0; i < -ei; i++) v = v / 2.0;
    ex = 0;
    t  = v;
    while (t >= 2.0) begin t = t / 2.0; ex++; end
    while (t < 1.0)  begin t = t * 2.0; ex--; end
    qe = ((ex < -14) ? -14 : ex) - 10;
    n  = v;
    if (qe > 0) for (int i = 0; i < qe; i++) n = n / 2.0;
    else        for (int i = 0; i < -qe; i++) n = n * 2.0;
    rn = $rtoi(n);
    fr = n - real'(rn);
    if (fr > 0.5 || (fr == 0.5 && (rn % 2) == 1)) rn++;
    if (rn == 2048) begin rn = 1024; ex++; end
    if (ex > 15) return {s, 15'h7C00};
    if (rn == 0) return 16'h0000;
    if (ex < -14) return {s, 15'(rn)};
    return {s, 5'(ex + 15), 10'(rn - 1024)};
  endfunction

  // Expected output state, advanced on the same edge the DUT samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_res   <= 16'h0000;
      exp_known <= 1'b1;
    end else begin
      exp_valid <= valid;
      if (valid) exp_res <= ref_fp16(m, e);
    end
  end

  // Compare process: pin the model on hand-computed values, then check every cycle.
  initial begin : compare
    logic [15:0] mv;
    total = 0;
    bad   = 0;
    for (int i = 0; i < NDIR; i++) begin
      mv = ref_fp16(DM[i], DE[i]);
      total++;
      if (mv !== DX[i]) begin
        bad++;
        $display("FAIL model_pin[%0d]: got %h want %h", i, mv, DX[i]);
      end
    end
    while (!done) begin
      @(negedge clk);
      if (exp_known === 1'b1) begin
        total++;
        if (res_valid !== exp_valid) begin
          bad++;
          $display("FAIL o_valid @%0t: got %b want %b", $time, res_valid, exp_valid);
        end
        total++;
        if (res !== exp_res) begin
          bad++;
          $display("FAIL o_fp16_result @%0t: got %h want %h", $time, res, exp_res);
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic step(input logic r, input logic v, input logic [31:0] mm, input logic [7:0] ee);
    @(posedge clk);
    #2;
    rst_n = r;
    valid = v;
    m     = mm;
    e     = ee;
  endtask

  function automatic logic [31:0] rand_man();
    logic [31:0] x;
    int          sel;
    sel = int'($urandom_range(0, 19));
    if (sel == 0)      x = 32'd0;
    else if (sel == 1) x = 32'h80000000;
    else begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
    end
    return x;
  endfunction

  function automatic logic [7:0] rand_exp();
    int x;
    if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 255));
    else x = int'($urandom_range(0, 70)) - 50;
    return 8'(x);
  endfunction

  // Stimulus driver.
  initial begin : driver
    done      = 1'b0;
    exp_known = 1'b0;
    exp_valid = 1'b0;
    exp_res   = 16'h0000;
    rst_n = 1'b0;
    valid = 1'b0;
    m     = 32'd0;
    e     = 8'd0;
    repeat (3) step(1'b0, 1'b0, 32'd0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 8'd0);
    // Directed vectors back to back, then idle so the last result must hold.
    for (int i = 0; i < NDIR; i++) step(1'b1, 1'b1, DM[i], DE[i]);
    repeat (3) step(1'b1, 1'b0, 32'd0, 8'd0);
    // Three consecutive random results, then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_man(), rand_exp());
    repeat (2) step(1'b1, 1'b0, 32'd0, 8'd0);
    // Reset in the same cycle as a valid input discards it.
    step(1'b1, 1'b1, 32'd1, 8'd0);
    step(1'b0, 1'b1, 32'd2051, 8'd0);
    step(1'b1, 1'b0, 32'd0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 8'd0);
    // Randomized traffic with sparse resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rand_man(), rand_exp());
    end
    repeat (3) step(1'b1, 1'b0, 32'd0, 8'd0);
    done = 1'b1;
  end

endmodule
